tt_um_tensor_flow_e: RTL and testbench

//  TinyTapeout top for a tiny tensor engine: 2x2 signed int8 matrix multiply, C = A x B (or C += A x B).

---
 rtl/tensor_pkg.sv | 52 +++++
 rtl/tt_um_tensor_flow_e_mac_sat16.sv | 26 ++
 rtl/tt_um_tensor_flow_e.sv | 165 ++++++++++++++++
 tb/tb_tt_um_tensor_flow_e.sv | 187 ++++++++++++++++++
 4 files changed

// File: rtl/tensor_pkg.sv
// Shared types and helpers for the 2x2 int8 tensor engine.
//   cmd_e      : 3-bit command encoding carried on uio_in[2:0]
//   sat_res_t  : saturated accumulator value plus clamp flag
//   sat16      : clamp a 17-bit signed sum to signed ACC_W
//   a_idx/b_idx/c_idx : MAC step (0..7) to row-major operand/result index
package tensor_pkg;

    localparam int unsigned ACC_W = 16;
    localparam int unsigned N     = 2;

    typedef enum logic [2:0] {
        CMD_NOP       = 3'd0,
        CMD_LOAD_A    = 3'd1,
        CMD_LOAD_B    = 3'd2,
        CMD_START     = 3'd3,
        CMD_READ      = 3'd4,
        CMD_CLEAR     = 3'd5,
        CMD_ACC_START = 3'd6,
        CMD_NOP7      = 3'd7
    } cmd_e;

    typedef struct packed {
        logic             sat;
        logic [ACC_W-1:0] val;
    } sat_res_t;

    // Overflow when the two top bits of the 17-bit sum disagree; clamp toward its sign.
    function automatic sat_res_t sat16(input logic [ACC_W:0] sum);
        sat_res_t r;
        r.sat = sum[ACC_W] ^ sum[ACC_W-1];
        if (r.sat) begin
            r.val = {sum[ACC_W], {(ACC_W-1){~sum[ACC_W]}}};
        end else begin
            r.val = sum[ACC_W-1:0];
        end
        return r;
    endfunction

    // Step s: e = s>>1, k = s&1, i = e>>1, j = e&1.
    function automatic logic [1:0] a_idx(input logic [2:0] s);
        return {s[2], s[0]};  // A[i][k]
    endfunction

    function automatic logic [1:0] b_idx(input logic [2:0] s);
        return {s[0], s[1]};  // B[k][j]
    endfunction

    function automatic logic [1:0] c_idx(input logic [2:0] s);
        return s[2:1];        // C[e]
    endfunction

endpackage

// File: rtl/tt_um_tensor_flow_e_mac_sat16.sv
// Combinational saturating MAC: sum_o = sat16(c_i + a_i * b_i).
//   a_i, b_i : signed int8 operands
//   c_i      : signed int16 accumulator input
//   sum_o    : saturated signed int16 result
//   sat_o    : high when the result was clamped
module mac_sat16
    import tensor_pkg::*;
(
    input  logic signed [7:0]       a_i,
    input  logic signed [7:0]       b_i,
    input  logic        [ACC_W-1:0] c_i,
    output logic        [ACC_W-1:0] sum_o,
    output logic                    sat_o
);

    logic signed [ACC_W-1:0] prod;
    logic        [ACC_W:0]   sum;
    sat_res_t                res;

    assign prod  = a_i * b_i;
    assign sum   = {c_i[ACC_W-1], c_i} + {prod[ACC_W-1], prod};
    assign res   = sat16(sum);
    assign sum_o = res.val;
    assign sat_o = res.sat;

endmodule

// File: rtl/tt_um_tensor_flow_e.sv
// TinyTapeout top: 2x2 signed int8 matrix multiply C = A x B (or C += A x B)
// computed by one shared MAC over 8 cycles.
//   clk, rst : clock, asynchronous active-high reset
//   ena      : low = commands ignored; an in-flight compute still completes
//   ui_in    : operand byte for LOAD_A/LOAD_B
//   uio_in   : [2:0] cmd, [3] cmd_valid
//   uo_out   : read-data byte register
//   uio_out  : [4] busy, [5] done, [6] sat
//   uio_oe   : constant 8'hF0
module tt_um_tensor_flow_e
    import tensor_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       ena,
    input  logic [7:0] ui_in,
    input  logic [7:0] uio_in,
    output logic [7:0] uo_out,
    output logic [7:0] uio_out,
    output logic [7:0] uio_oe
);

    localparam logic [0:0] StIdle = 1'b0;
    localparam logic [0:0] StRun  = 1'b1;

    logic [7:0]       a_q [4];
    logic [7:0]       a_d [4];
    logic [7:0]       b_q [4];
    logic [7:0]       b_d [4];
    logic [ACC_W-1:0] c_q [4];
    logic [ACC_W-1:0] c_d [4];
    logic [1:0]       a_ptr_q, a_ptr_d, b_ptr_q, b_ptr_d;
    logic [2:0]       rd_ptr_q, rd_ptr_d, step_q, step_d;
    logic [0:0]       state_q, state_d;
    logic             done_q, done_d, sat_q, sat_d;
    logic [7:0]       uo_q, uo_d;

    logic             busy, cmd_fire;
    cmd_e             cmd;
    logic [ACC_W-1:0] mac_sum;
    logic             mac_sat;
    logic [ACC_W-1:0] rd_word;
    logic [3:0]       unused_uio_in;

    assign unused_uio_in = uio_in[7:4];
    assign busy          = (state_q == StRun);
    assign cmd_fire      = ena & uio_in[3];
    assign cmd           = cmd_e'(uio_in[2:0]);
    assign rd_word       = c_q[rd_ptr_q[2:1]];

    mac_sat16 u_mac (
        .a_i   (a_q[a_idx(step_q)]),
        .b_i   (b_q[b_idx(step_q)]),
        .c_i   (c_q[c_idx(step_q)]),
        .sum_o (mac_sum),
        .sat_o (mac_sat)
    );

    always_comb begin
        a_d      = a_q;
        b_d      = b_q;
        c_d      = c_q;
        a_ptr_d  = a_ptr_q;
        b_ptr_d  = b_ptr_q;
        rd_ptr_d = rd_ptr_q;
        step_d   = step_q;
        state_d  = state_q;
        done_d   = done_q;
        sat_d    = sat_q;
        uo_d     = uo_q;

        if (busy) begin
            c_d[c_idx(step_q)] = mac_sum;
            if (mac_sat) begin
                sat_d = 1'b1;
            end
            step_d = step_q + 3'd1;
            if (step_q == 3'd7) begin
                state_d = StIdle;
                done_d  = 1'b1;
            end
        end

        // Evaluated after the compute step so CLEAR overrides an in-flight MAC.
        if (cmd_fire) begin
            case (cmd)
                CMD_LOAD_A: if (!busy) begin
                    a_d[a_ptr_q] = ui_in;
                    a_ptr_d      = a_ptr_q + 2'd1;
                end
                CMD_LOAD_B: if (!busy) begin
                    b_d[b_ptr_q] = ui_in;
                    b_ptr_d      = b_ptr_q + 2'd1;
                end
                CMD_START, CMD_ACC_START: if (!busy) begin
                    if (cmd == CMD_START) begin
                        for (int i = 0; i < 4; i++) c_d[i] = '0;
                    end
                    done_d   = 1'b0;
                    sat_d    = 1'b0;
                    a_ptr_d  = '0;
                    b_ptr_d  = '0;
                    rd_ptr_d = '0;
                    step_d   = '0;
                    state_d  = StRun;
                end
                CMD_READ: if (!busy) begin
                    uo_d     = rd_ptr_q[0] ? rd_word[15:8] : rd_word[7:0];
                    rd_ptr_d = rd_ptr_q + 3'd1;
                end
                CMD_CLEAR: begin
                    for (int i = 0; i < 4; i++) begin
                        a_d[i] = '0;
                        b_d[i] = '0;
                        c_d[i] = '0;
                    end
                    a_ptr_d  = '0;
                    b_ptr_d  = '0;
                    rd_ptr_d = '0;
                    step_d   = '0;
                    state_d  = StIdle;
                    done_d   = 1'b0;
                    sat_d    = 1'b0;
                    uo_d     = '0;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 4; i++) begin
                a_q[i] <= '0;
                b_q[i] <= '0;
                c_q[i] <= '0;
            end
            a_ptr_q  <= '0;
            b_ptr_q  <= '0;
            rd_ptr_q <= '0;
            step_q   <= '0;
            state_q  <= StIdle;
            done_q   <= 1'b0;
            sat_q    <= 1'b0;
            uo_q     <= '0;
        end else begin
            a_q      <= a_d;
            b_q      <= b_d;
            c_q      <= c_d;
            a_ptr_q  <= a_ptr_d;
            b_ptr_q  <= b_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            step_q   <= step_d;
            state_q  <= state_d;
            done_q   <= done_d;
            sat_q    <= sat_d;
            uo_q     <= uo_d;
        end
    end

    assign uo_out  = uo_q;
    assign uio_out = {1'b0, sat_q, done_q, busy, 4'b0000};
    assign uio_oe  = 8'hF0;

endmodule

// File: tb/tb_tt_um_tensor_flow_e.sv
module tb_tt_um_tensor_flow_e;
    import tensor_pkg::*;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       ena = 1'b1;
    logic [7:0] ui_in = 8'h00;
    logic [7:0] uio_in = 8'h00;
    logic [7:0] uo_out, uio_out, uio_oe;

    int n_checks = 0;
    int n_fail   = 0;
    logic [7:0] exp_q [$];

    tt_um_tensor_flow_e dut (
        .clk     (clk),
        .rst     (rst),
        .ena     (ena),
        .ui_in   (ui_in),
        .uio_in  (uio_in),
        .uo_out  (uo_out),
        .uio_out (uio_out),
        .uio_oe  (uio_oe)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: every accepted READ is compared against the scoreboard head.
    initial begin
        logic fire;
        logic [7:0] e;
        forever begin
            @(posedge clk);
            fire = ena && uio_in[3] && (uio_in[2:0] == CMD_READ) && !rst;
            @(negedge clk);
            if (fire) begin
                if (exp_q.size() == 0) begin
                    check("read_unexpected", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    check("read_byte", uo_out, e);
                end
            end
        end
    end

    task automatic do_cmd(input cmd_e c, input logic [7:0] d);
        ui_in  = d;
        uio_in = {4'b0000, 1'b1, c};
        @(posedge clk);
        #1;
        uio_in = 8'h00;
    endtask

    task automatic do_read(input logic [7:0] e);
        exp_q.push_back(e);
        do_cmd(CMD_READ, 8'h00);
    endtask

    task automatic load(input logic [31:0] a, input logic [31:0] b);
        for (int i = 0; i < 4; i++) do_cmd(CMD_LOAD_A, a[31-8*i -: 8]);
        for (int i = 0; i < 4; i++) do_cmd(CMD_LOAD_B, b[31-8*i -: 8]);
    endtask

    task automatic wait_done();
        int n = 0;
        while (!uio_out[5] && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("done_within_budget", int'(uio_out[5]), 1);
    endtask

    task automatic read_all(input logic [63:0] bytes);
        for (int i = 0; i < 8; i++) do_read(bytes[63-8*i -: 8]);
    endtask

    initial begin
        int cnt;
        logic pb, pd, fell;

        #12;
        check("reset_uo_out", uo_out, 8'h00);
        check("reset_uio_out", uio_out, 8'h00);
        check("uio_oe", uio_oe, 8'hF0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // 1: [1,2;3,4] x [5,6;7,8]
        load({8'd1, 8'd2, 8'd3, 8'd4}, {8'd5, 8'd6, 8'd7, 8'd8});
        do_cmd(CMD_START, 8'h00);
        wait_done();
        check("t1_sat", int'(uio_out[6]), 0);
        read_all({8'd19, 8'd0, 8'd22, 8'd0, 8'd43, 8'd0, 8'd50, 8'd0});
        do_read(8'd19);  // rd_ptr wraps

        // 2: accumulate once more
        do_cmd(CMD_ACC_START, 8'h00);
        wait_done();
        read_all({8'd38, 8'd0, 8'd44, 8'd0, 8'd86, 8'd0, 8'd100, 8'd0});

        // 3: positive saturation
        load({4{8'h80}}, {4{8'h80}});
        do_cmd(CMD_START, 8'h00);
        wait_done();
        check("t3_sat", int'(uio_out[6]), 1);
        read_all({4{8'hFF, 8'h7F}});

        // 4: negative results
        load({8'hFF, 8'h00, 8'h00, 8'hFF}, {8'h03, 8'h00, 8'h00, 8'h03});
        do_cmd(CMD_START, 8'h00);
        wait_done();
        check("t4_sat", int'(uio_out[6]), 0);
        read_all({8'hFD, 8'hFF, 8'h00, 8'h00, 8'h00, 8'h00, 8'hFD, 8'hFF});

        // 5: busy window, done timing, LOAD_A ignored while busy
        do_cmd(CMD_START, 8'h00);
        cnt = 0; pb = 1'b1; pd = 1'b0; fell = 1'b0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (uio_out[4]) cnt++;
            if (pb && !uio_out[4]) begin
                fell = 1'b1;
                check("t5_done_rises_with_busy_fall", {30'd0, pd, uio_out[5]}, 1);
            end
            pb = uio_out[4];
            pd = uio_out[5];
            if (i == 2) begin
                ui_in  = 8'h55;
                uio_in = {4'b0000, 1'b1, CMD_LOAD_A};
            end
            if (i == 3) uio_in = 8'h00;
        end
        check("t5_busy_cycles", cnt, 8);
        check("t5_busy_fell", int'(fell), 1);
        read_all({8'hFD, 8'hFF, 8'h00, 8'h00, 8'h00, 8'h00, 8'hFD, 8'hFF});

        // 6a: rst mid-compute
        load({4{8'h80}}, {4{8'h80}});
        do_cmd(CMD_START, 8'h00);
        repeat (4) @(negedge clk);
        check("t6_sat_before_rst", int'(uio_out[6]), 1);
        rst = 1'b1;
        #1;
        check("t6_rst_uio_out", uio_out, 8'h00);
        check("t6_rst_uo_out", uo_out, 8'h00);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        do_read(8'h00);

        // 6b: CLEAR mid-compute
        load({4{8'h80}}, {4{8'h80}});
        do_cmd(CMD_START, 8'h00);
        wait_done();
        do_read(8'hFF);
        do_cmd(CMD_START, 8'h00);
        repeat (3) @(negedge clk);
        do_cmd(CMD_CLEAR, 8'h00);
        @(negedge clk);
        check("t6_clr_uio_out", uio_out, 8'h00);
        check("t6_clr_uo_out", uo_out, 8'h00);
        do_read(8'h00);
        do_read(8'h00);

        repeat (3) @(negedge clk);
        check("scoreboard_drained", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, expected completion");
        $fatal(1);
    end

endmodule
